cs_strobe_sched: RTL and testbench

- Round-robin scheduler that shares one 3-to-8 chip-select decoder among up to 8 requesters in the TTM4 emulator bus logic.
- Picks one requester and drives the decoder address and enables.
- Sequences each access through a timed SETUP / STROBE / HOLD window, so exactly one active-low select pulses per grant.
- Also produces the decoded active-low selects nCS internally, matching decoder semantics.

---
 rtl/cs_sched_pkg.sv | 19 +
 rtl/cs_rr_pick.sv | 25 ++
 rtl/cs_strobe_sched.sv | 113 +++++++++++
 tb/tb_cs_strobe_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs_sched_pkg.sv
// rtl/cs_sched_pkg.sv - shared types and constants for the chip-select strobe scheduler
package cs_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [2:0] E_ON  = 3'b100;
    localparam logic [2:0] E_OFF = 3'b000;
    localparam int         CNT_W = 4;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/cs_rr_pick.sv
// rtl/cs_rr_pick.sv - combinational round-robin pick: first set request after i_ptr, wrapping mod 8
module cs_rr_pick (
    input  logic [7:0] i_req,
    input  logic [2:0] i_ptr,
    output logic       o_valid,
    output logic [2:0] o_idx
);

    logic [2:0] w_cand;

    // Offset 8 wraps back to i_ptr itself, so the last holder is checked last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        w_cand  = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_cand = i_ptr + 3'(i);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/cs_strobe_sched.sv
// rtl/cs_strobe_sched.sv - shares one 3-to-8 chip-select decoder among 8 requesters
// with a timed SETUP / STROBE / HOLD window per grant.
module cs_strobe_sched
    import cs_sched_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] A,
    output logic [2:0] E,
    output logic [7:0] nCS,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ptr;
    logic [7:0]       r_gnt;
    logic [2:0]       r_a;
    logic [2:0]       r_e;
    logic [7:0]       r_ncs;
    logic             r_busy;
    logic             r_done;

    logic             w_valid;
    logic [2:0]       w_idx;

    cs_rr_pick u_pick (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // nCS is updated on the same edge as E, decoded from the A/E being loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= 3'd7;
            r_gnt   <= 8'h00;
            r_a     <= 3'd0;
            r_e     <= E_OFF;
            r_ncs   <= 8'hFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= SETUP;
                        r_cnt   <= SETUP_LD;
                        r_gnt   <= onehot8(w_idx);
                        r_a     <= w_idx;
                        r_ptr   <= w_idx;
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= STROBE;
                        r_cnt   <= STROBE_LD;
                        r_e     <= E_ON;
                        r_ncs   <= ~onehot8(r_a);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= HOLD;
                        r_cnt   <= HOLD_LD;
                        r_e     <= E_OFF;
                        r_ncs   <= 8'hFF;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_gnt   <= 8'h00;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GNT  = r_gnt;
    assign A    = r_a;
    assign E    = r_e;
    assign nCS  = r_ncs;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_cs_strobe_sched.sv
// tb/tb_cs_strobe_sched.sv - directed self-checking bench for cs_strobe_sched
module tb_cs_strobe_sched;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] REQ = 8'h00;
    logic [7:0] GNT;
    logic [2:0] A;
    logic [2:0] E;
    logic [7:0] nCS;
    logic       BUSY;
    logic       DONE;

    logic       RST2 = 1'b1;
    logic [7:0] REQ2 = 8'h00;
    logic [7:0] GNT2;
    logic [2:0] A2;
    logic [2:0] E2;
    logic [7:0] nCS2;
    logic       BUSY2;
    logic       DONE2;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    cs_strobe_sched dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .GNT  (GNT),
        .A    (A),
        .E    (E),
        .nCS  (nCS),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    cs_strobe_sched #(
        .SETUP_CYC  (3),
        .STROBE_CYC (1),
        .HOLD_CYC   (2)
    ) dut2 (
        .CLK  (CLK),
        .RST  (RST2),
        .REQ  (REQ2),
        .GNT  (GNT2),
        .A    (A2),
        .E    (E2),
        .nCS  (nCS2),
        .BUSY (BUSY2),
        .DONE (DONE2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called just after the grant edge with default timing (1/2/1); returns on the DONE cycle.
    task automatic check_txn(input logic [2:0] idx, input string tag);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        chk({tag, "_gnt"},  GNT, oh);
        chk({tag, "_a"},    {5'd0, A}, {5'd0, idx});
        chk({tag, "_busy"}, {7'd0, BUSY}, 8'd1);
        chk({tag, "_setup_ncs"}, nCS, 8'hFF);
        chk({tag, "_setup_e"},   {5'd0, E}, 8'h00);
        tick();
        chk({tag, "_strobe1_ncs"}, nCS, ~oh);
        chk({tag, "_strobe1_e"},   {5'd0, E}, 8'h04);
        tick();
        chk({tag, "_strobe2_ncs"}, nCS, ~oh);
        tick();
        chk({tag, "_hold_ncs"},  nCS, 8'hFF);
        chk({tag, "_hold_e"},    {5'd0, E}, 8'h00);
        chk({tag, "_hold_gnt"},  GNT, oh);
        chk({tag, "_hold_busy"}, {7'd0, BUSY}, 8'd1);
        chk({tag, "_hold_done"}, {7'd0, DONE}, 8'd0);
        tick();
        chk({tag, "_done"},      {7'd0, DONE}, 8'd1);
        chk({tag, "_done_busy"}, {7'd0, BUSY}, 8'd0);
        chk({tag, "_done_gnt"},  GNT, 8'h00);
        chk({tag, "_done_a"},    {5'd0, A}, {5'd0, idx});
    endtask

    // Invariants on both instances, sampled on the falling edge.
    always @(negedge CLK) begin
        if (E === 3'b100) begin
            chk("inv_pop",    8'($countones(~nCS)), 8'd1);
            chk("inv_gnt_oh", GNT, 8'h01 << A);
        end
        if (E2 === 3'b100) begin
            chk("inv2_pop",    8'($countones(~nCS2)), 8'd1);
            chk("inv2_gnt_oh", GNT2, 8'h01 << A2);
        end
        if (!$isunknown(nCS2) && $countones(~nCS2) > 1)
            chk("inv2_multi_low", nCS2, 8'hFF);
        if (!$isunknown(nCS) && $countones(~nCS) > 1)
            chk("inv_multi_low", nCS, 8'hFF);
    end

    initial begin
        // Reset held for 2 cycles with all requests up.
        RST = 1'b1;
        REQ = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt",  GNT, 8'h00);
            chk("rst_a",    {5'd0, A}, 8'h00);
            chk("rst_e",    {5'd0, E}, 8'h00);
            chk("rst_ncs",  nCS, 8'hFF);
            chk("rst_busy", {7'd0, BUSY}, 8'd0);
            chk("rst_done", {7'd0, DONE}, 8'd0);
        end
        RST = 1'b0;
        tick();
        REQ = 8'h00;
        check_txn(3'd0, "first");
        tick();
        chk("first_done_clear", {7'd0, DONE}, 8'd0);
        chk("first_idle_busy",  {7'd0, BUSY}, 8'd0);

        // Round robin across requesters 2, 5, 7 from a fresh pointer.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ = 8'b1010_0100;
        tick();
        check_txn(3'd2, "rr0");
        tick();
        check_txn(3'd5, "rr1");
        tick();
        check_txn(3'd7, "rr2");
        tick();
        REQ = 8'h00;
        check_txn(3'd2, "rr3");
        tick();
        chk("rr_idle_busy", {7'd0, BUSY}, 8'd0);
        chk("rr_idle_done", {7'd0, DONE}, 8'd0);

        // Single requester re-granted on the DONE edge.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ = 8'h08;
        tick();
        check_txn(3'd3, "single0");
        tick();
        REQ = 8'h00;
        check_txn(3'd3, "single1");
        tick();
        chk("single_idle_busy", {7'd0, BUSY}, 8'd0);

        // One-cycle request still completes the whole window.
        REQ = 8'h40;
        tick();
        REQ = 8'h00;
        check_txn(3'd6, "drop");
        tick();
        chk("drop_idle_busy", {7'd0, BUSY}, 8'd0);
        chk("drop_idle_gnt",  GNT, 8'h00);

        // Reset during the first STROBE cycle; pointer is 6 here, so REQ=02 picks 1.
        REQ = 8'h02;
        tick();
        REQ = 8'h00;
        chk("abort_gnt", GNT, 8'h02);
        tick();
        chk("abort_strobe_ncs", nCS, 8'hFD);
        RST = 1'b1;
        tick();
        chk("abort_ncs",  nCS, 8'hFF);
        chk("abort_e",    {5'd0, E}, 8'h00);
        chk("abort_gnt0", GNT, 8'h00);
        chk("abort_done", {7'd0, DONE}, 8'd0);
        chk("abort_busy", {7'd0, BUSY}, 8'd0);
        RST = 1'b0;
        REQ = 8'h81;
        tick();
        REQ = 8'h00;
        check_txn(3'd0, "post_abort");
        tick();

        // Second instance: SETUP=3, STROBE=1, HOLD=2.
        tick();
        RST2 = 1'b0;
        REQ2 = 8'h10;
        tick();
        REQ2 = 8'h00;
        chk("sw_gnt",  GNT2, 8'h10);
        chk("sw_a",    {5'd0, A2}, 8'h04);
        chk("sw_busy", {7'd0, BUSY2}, 8'd1);
        chk("sw_setup0_ncs", nCS2, 8'hFF);
        tick();
        chk("sw_setup1_ncs", nCS2, 8'hFF);
        tick();
        chk("sw_setup2_ncs", nCS2, 8'hFF);
        tick();
        chk("sw_strobe_ncs", nCS2, 8'hEF);
        chk("sw_strobe_e",   {5'd0, E2}, 8'h04);
        tick();
        chk("sw_hold0_ncs",  nCS2, 8'hFF);
        chk("sw_hold0_busy", {7'd0, BUSY2}, 8'd1);
        tick();
        chk("sw_hold1_busy", {7'd0, BUSY2}, 8'd1);
        chk("sw_hold1_gnt",  GNT2, 8'h10);
        chk("sw_hold1_done", {7'd0, DONE2}, 8'd0);
        tick();
        chk("sw_done",      {7'd0, DONE2}, 8'd1);
        chk("sw_done_busy", {7'd0, BUSY2}, 8'd0);
        chk("sw_done_gnt",  GNT2, 8'h00);
        tick();
        chk("sw_done_clear", {7'd0, DONE2}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
